// File: rtl/sram_like_resp.sv
`default_nettype none
// ============================================================================
// sram_like_resp : sram-like data responder, word RAM + in-order latency queue
// Revision 1.0
// ============================================================================
module sram_like_resp #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        stall_in,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [2:0]  outstanding
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [TW-1:0] C_TIMER_INIT = TW'(LATENCY - 1);
  localparam logic [PW-1:0] C_PTR_LAST   = PW'(DEPTH - 1);
  localparam logic [2:0]    C_DEPTH      = 3'(DEPTH);

  logic [31:0]       r_mem [2**ADDR_W];
  logic [TW-1:0]     r_timer [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic [DEPTH-1:0]  r_is_wr;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [2:0]        r_count;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_idx;
  logic              w_unused;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_idx    = addr[ADDR_W+1:2];
  assign w_unused = &{1'b0, addr[31:ADDR_W+2], addr[1:0], size};

  // Acceptance looks only at the registered count, so a same-cycle retire
  // never frees a slot early and there is no path from data_ok.
  assign addr_ok     = req & ~stall_in & (r_count < C_DEPTH);
  assign w_push      = addr_ok;
  assign data_ok     = (r_count != 3'd0) && (r_timer[r_head] == '0);
  assign w_pop       = data_ok;
  assign rdata       = (data_ok && !r_is_wr[r_head]) ? r_data[r_head] : 32'd0;
  assign outstanding = r_count;

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= f_next(r_tail);
      if (w_pop)  r_head <= f_next(r_head);
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (!w_push && w_pop) r_count <= r_count - 3'd1;
    end
  end

  // Read data is the pre-edge RAM word; a write in the same slot stores zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_timer[i] <= '0;
        r_data[i]  <= '0;
      end
      r_is_wr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_tail == PW'(i))) begin
          r_timer[i] <= C_TIMER_INIT;
          r_is_wr[i] <= wr;
          r_data[i]  <= wr ? 32'd0 : r_mem[w_idx];
        end else if (r_timer[i] != '0) begin
          r_timer[i] <= r_timer[i] - 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sram_like_resp.sv
`default_nettype none
// tb_sram_like_resp: directed + randomized traffic checked every cycle against
// a queue/array reference model of the responder.
module tb_sram_like_resp;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 2;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        stall_in = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [2:0]  outstanding;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int peak  = 0;

  // Reference model: word array plus FIFO of (due cycle, response data).
  logic [31:0] mram [2**ADDR_W];
  int          mq_due[$];
  logic [31:0] mq_dat[$];
  // Observed responses, consumed by directed checks.
  int          resp_c[$];
  logic [31:0] resp_d[$];
  logic [31:0] init_val [16];

  sram_like_resp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .stall_in(stall_in), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .outstanding(outstanding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic              m_aok;
  logic              m_dok;
  logic [31:0]       m_rd;
  logic [ADDR_W-1:0] m_idx;

  always @(negedge clk) begin
    if (!resetn) begin
      mq_due.delete();
      mq_dat.delete();
      chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
    end else begin
      m_aok = req && !stall_in && (mq_due.size() < DEPTH);
      m_dok = (mq_due.size() > 0) && (mq_due[0] <= cyc);
      m_rd  = m_dok ? mq_dat[0] : 32'd0;
      chk("addr_ok", {31'd0, addr_ok}, {31'd0, m_aok});
      chk("data_ok", {31'd0, data_ok}, {31'd0, m_dok});
      chk("rdata", rdata, m_rd);
      chk("outstanding", {29'd0, outstanding}, 32'(mq_due.size()));
      if (int'(outstanding) > peak) peak = int'(outstanding);
      if (data_ok) begin
        resp_c.push_back(cyc);
        resp_d.push_back(rdata);
      end
      if (m_dok) begin
        void'(mq_due.pop_front());
        void'(mq_dat.pop_front());
      end
      if (m_aok) begin
        m_idx = addr[ADDR_W+1:2];
        mq_due.push_back(cyc + LATENCY);
        mq_dat.push_back(wr ? 32'd0 : mram[m_idx]);
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (wstrb[i]) mram[m_idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 1'b0; wr = 1'b0; stall_in = 1'b0; wstrb = '0;
  endtask

  // Called 1 time unit after a rising edge; returns aligned the same way.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int hs, output int rej);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'b10; stall_in = 1'b0;
    hs = -1; rej = 0;
    for (int n = 0; n < 20 && hs < 0; n++) begin
      @(negedge clk);
      if (addr_ok) hs = cyc; else rej++;
      @(posedge clk); #1;
    end
    if (hs < 0) begin
      total++; bad++;
      $display("FAIL issue_timeout: addr %h never accepted", a);
    end
  endtask

  task automatic wait_resp(output int c, output logic [31:0] d);
    int n;
    n = 0;
    while (resp_c.size() == 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (resp_c.size() == 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: no data_ok within %0d cycles", n);
      c = -1; d = 'x;
    end else begin
      c = resp_c.pop_front();
      d = resp_d.pop_front();
    end
  endtask

  initial begin
    int hs, rej, hs0, hs1, hs2, rej0, rej1, rej2, c0, c1, c2, cnt;
    logic [31:0] d0, d1, d2;
    step(2);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      init_val[i] = $urandom;
      issue(1'b1, 32'(i * 4), 4'hF, init_val[i], hs, rej);
    end
    idle(); step(4);
    resp_c.delete(); resp_d.delete();

    // Full-word write then read back.
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, hs, rej); idle();
    wait_resp(c0, d0);
    chk("t1_wr_latency", 32'(c0 - hs), 32'd2);
    chk("t1_wr_rdata", d0, 32'd0);
    step(1);
    issue(1'b0, 32'h10, 4'h0, 32'd0, hs, rej); idle();
    wait_resp(c0, d0);
    chk("t1_rd_latency", 32'(c0 - hs), 32'd2);
    chk("t1_rd_rdata", d0, 32'hDEADBEEF);
    step(1);

    // Single byte lane write.
    issue(1'b1, 32'h12, 4'b0100, 32'hAAAAAAAA, hs, rej); idle();
    wait_resp(c0, d0);
    step(1);
    issue(1'b0, 32'h10, 4'h0, 32'd0, hs, rej); idle();
    wait_resp(c0, d0);
    chk("t2_byte_merge", d0, 32'hDEAABEEF);
    step(1);

    // Queue full: third back-to-back read waits one cycle.
    peak = 0;
    issue(1'b0, 32'h10, 4'h0, 32'd0, hs0, rej0);
    issue(1'b0, 32'h14, 4'h0, 32'd0, hs1, rej1);
    issue(1'b0, 32'h18, 4'h0, 32'd0, hs2, rej2);
    idle();
    wait_resp(c0, d0); wait_resp(c1, d1); wait_resp(c2, d2);
    chk("t3_second_hs", 32'(hs1 - hs0), 32'd1);
    chk("t3_third_rej", 32'(rej2), 32'd1);
    chk("t3_third_hs", 32'(hs2 - hs0), 32'd3);
    chk("t3_resp0_cycle", 32'(c0 - hs0), 32'd2);
    chk("t3_resp1_cycle", 32'(c1 - hs0), 32'd3);
    chk("t3_resp2_cycle", 32'(c2 - hs0), 32'd5);
    chk("t3_resp0_data", d0, 32'hDEAABEEF);
    chk("t3_resp1_data", d1, init_val[5]);
    chk("t3_resp2_data", d2, init_val[6]);
    chk("t3_peak", 32'(peak), 32'd2);
    step(1);

    // Throttle.
    req = 1'b1; wr = 1'b0; addr = 32'h10; wstrb = '0; stall_in = 1'b1; cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (addr_ok) cnt++;
      @(posedge clk); #1;
    end
    chk("t4_stall_aok_count", 32'(cnt), 32'd0);
    issue(1'b0, 32'h10, 4'h0, 32'd0, hs, rej); idle();
    chk("t4_release_rej", 32'(rej), 32'd0);
    wait_resp(c0, d0);
    chk("t4_latency", 32'(c0 - hs), 32'd2);
    chk("t4_rdata", d0, 32'hDEAABEEF);
    step(1);

    // Reset while a read is in flight.
    resp_c.delete(); resp_d.delete();
    issue(1'b0, 32'h20, 4'h0, 32'd0, hs, rej); idle();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    @(negedge clk);
    chk("t5_outstanding", {29'd0, outstanding}, 32'd0);
    step(6);
    chk("t5_no_resp", 32'(resp_c.size()), 32'd0);
    issue(1'b0, 32'h10, 4'h0, 32'd0, hs, rej); idle();
    wait_resp(c0, d0);
    chk("t5_ram_kept", d0, 32'hDEAABEEF);
    step(1);

    // Write then read same word back-to-back.
    issue(1'b1, 32'h20, 4'hF, 32'h5A5A5A5A, hs0, rej0);
    issue(1'b0, 32'h20, 4'h0, 32'd0, hs1, rej1);
    idle();
    wait_resp(c0, d0); wait_resp(c1, d1);
    chk("t6_hs_gap", 32'(hs1 - hs0), 32'd1);
    chk("t6_resp_gap", 32'(c1 - c0), 32'd1);
    chk("t6_wr_rdata", d0, 32'd0);
    chk("t6_rd_rdata", d1, 32'h5A5A5A5A);
    step(1);

    // Random traffic over the initialised words, with one mid-run reset.
    for (int k = 0; k < 400; k++) begin
      req      = ($urandom_range(0, 9) < 7);
      wr       = 1'($urandom);
      stall_in = ($urandom_range(0, 9) < 2);
      size     = 2'($urandom_range(0, 2));
      addr     = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'd3);
      wstrb    = 4'($urandom);
      wdata    = $urandom;
      if (k == 200) begin
        req = 1'b0;
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
      end
      step(1);
    end
    idle();
    step(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
